// File: rtl/senseye_spi_pkg.sv
// Shared SPI constants, state encoding and the MCP3201 bit-framing helper.
package senseye_spi_pkg;

  localparam int MCP3201_BITS = 12;
  localparam int NULL_FALL    = 2;
  localparam int MSB_END_FALL = 14;
  localparam int LSB_END_FALL = 25;
  localparam int NF_W         = 5;

  typedef logic [NF_W-1:0]         nf_t;
  typedef logic [MCP3201_BITS-1:0] sample_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Returns {miso_oe, miso} for the given count of SPICLK falling edges.
  function automatic logic [1:0] mcp_bit(input nf_t nf, input sample_t sh, input logic tail);
    logic [1:0] r;
    logic [3:0] idx;
    r   = 2'b00;
    idx = 4'd0;
    if (nf < nf_t'(NULL_FALL)) begin
      r = 2'b00;
    end else if (nf == nf_t'(NULL_FALL)) begin
      r = 2'b10;
    end else if (nf <= nf_t'(MSB_END_FALL)) begin
      idx = 4'(nf_t'(MSB_END_FALL) - nf);
      r   = {1'b1, sh[idx]};
    end else if (nf <= nf_t'(LSB_END_FALL)) begin
      idx = 4'(nf - nf_t'(MSB_END_FALL));
      r   = {1'b1, tail & sh[idx]};
    end else begin
      r = 2'b10;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcp3201_emu_if.sv
// SPI pin bundle between the capture master and the MCP3201 emulator.
interface mcp3201_emu_if;
  logic spiclk;
  logic csn;
  logic miso;
  logic miso_oe;

  modport master (output spiclk, output csn, input miso, input miso_oe);
  modport slave  (input spiclk, input csn, output miso, output miso_oe);
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // Synchronizer chain followed by a one-flop edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
      rise_r <= sync_r[STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[STAGES-1] & prev_r;
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/mcp3201_emu.sv
// SPI responder that serves a host-supplied 12-bit sample with MCP3201 framing.
module mcp3201_emu
  import senseye_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_TAIL    = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  mcp3201_emu_if.slave            spi,
  input  logic [MCP3201_BITS-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    loaded,
  output logic                    frame_done,
  output logic                    frame_abort
);

  logic sck_fall_s, sck_rise_unused_s, sck_lvl_unused_s;
  logic csn_fall_s, csn_rise_s, csn_lvl_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(resetn), .din(spi.spiclk),
    .level(sck_lvl_unused_s), .rise(sck_rise_unused_s), .fall(sck_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
    .clk(clk), .rst_n(resetn), .din(spi.csn),
    .level(csn_lvl_s), .rise(csn_rise_s), .fall(csn_fall_s)
  );

  logic [SYNC_STAGES:0] flush_r;
  logic                 armed_r;
  logic [0:0]           state_r, state_s;
  sample_t              hold_r, sh_r, sh_s;
  nf_t                  nf_r, nf_s;
  logic                 miso_r, oe_r, loaded_r, done_r, abort_r;
  logic                 loaded_s, done_s, abort_s;
  logic [1:0]           out_s;

  // Frame sequencing; CSN rise takes priority over a coincident SPICLK fall.
  always_comb begin
    state_s  = state_r;
    sh_s     = sh_r;
    nf_s     = nf_r;
    loaded_s = 1'b0;
    done_s   = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (csn_fall_s && armed_r) begin
          state_s  = ST_FRAME;
          sh_s     = hold_r;
          nf_s     = 5'd0;
          loaded_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (csn_rise_s) begin
          state_s = ST_IDLE;
          done_s  = (nf_r >= nf_t'(MSB_END_FALL));
          abort_s = (nf_r <  nf_t'(MSB_END_FALL));
        end else if (sck_fall_s && (nf_r != 5'd31)) begin
          nf_s = nf_r + 5'd1;
        end else begin
          nf_s = nf_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (state_s == ST_FRAME) begin
      out_s = mcp_bit(nf_s, sh_s, LSB_TAIL);
    end else begin
      out_s = 2'b00;
    end
  end

  // A CSN fall is only honoured after CSN has been seen high since reset,
  // so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_r <= '0;
      armed_r <= 1'b0;
    end else begin
      flush_r <= {flush_r[SYNC_STAGES-1:0], 1'b1};
      armed_r <= armed_r | (flush_r[SYNC_STAGES] & csn_lvl_s);
    end
  end

  // State, holding/shift registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      hold_r   <= '0;
      sh_r     <= '0;
      nf_r     <= '0;
      miso_r   <= 1'b0;
      oe_r     <= 1'b0;
      loaded_r <= 1'b0;
      done_r   <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      if (sample_valid) begin
        hold_r <= sample_data;
      end
      sh_r     <= sh_s;
      nf_r     <= nf_s;
      oe_r     <= out_s[1];
      miso_r   <= out_s[0];
      loaded_r <= loaded_s;
      done_r   <= done_s;
      abort_r  <= abort_s;
    end
  end

  assign spi.miso    = miso_r;
  assign spi.miso_oe = oe_r;
  assign loaded      = loaded_r;
  assign frame_done  = done_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_mcp3201_emu.sv
// Table-driven bench: two emulators (tail on / 2-stage sync, tail off / 3-stage sync) on one SPI bus.
module tb_mcp3201_emu;

  logic        clk = 1'b0;
  logic        resetn, spiclk, csn, sample_valid;
  logic [11:0] sample_data;
  logic        ld_a, dn_a, ab_a, ld_b, dn_b, ab_b;
  int          n_cmp, n_fail;
  int          n_ld_a, n_dn_a, n_ab_a, n_ld_b, n_dn_b, n_ab_b, mon_err;
  logic        p_ld_a, p_dn_a, p_ab_a;

  always #20 clk = ~clk;

  mcp3201_emu_if if_a ();
  mcp3201_emu_if if_b ();
  assign if_a.spiclk = spiclk;
  assign if_a.csn    = csn;
  assign if_b.spiclk = spiclk;
  assign if_b.csn    = csn;

  mcp3201_emu #(.SYNC_STAGES(2), .LSB_TAIL(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .spi(if_a), .sample_data(sample_data),
    .sample_valid(sample_valid), .loaded(ld_a), .frame_done(dn_a), .frame_abort(ab_a)
  );
  mcp3201_emu #(.SYNC_STAGES(3), .LSB_TAIL(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .spi(if_b), .sample_data(sample_data),
    .sample_valid(sample_valid), .loaded(ld_b), .frame_done(dn_b), .frame_abort(ab_b)
  );

  // Pulse counters plus width/coincidence watch on the status pulses.
  initial begin
    n_ld_a = 0; n_dn_a = 0; n_ab_a = 0; n_ld_b = 0; n_dn_b = 0; n_ab_b = 0; mon_err = 0;
    p_ld_a = 1'b0; p_dn_a = 1'b0; p_ab_a = 1'b0;
  end
  always @(negedge clk) begin
    if (ld_a) n_ld_a <= n_ld_a + 1;
    if (dn_a) n_dn_a <= n_dn_a + 1;
    if (ab_a) n_ab_a <= n_ab_a + 1;
    if (ld_b) n_ld_b <= n_ld_b + 1;
    if (dn_b) n_dn_b <= n_dn_b + 1;
    if (ab_b) n_ab_b <= n_ab_b + 1;
    if ((ld_a && p_ld_a) || (dn_a && p_dn_a) || (ab_a && p_ab_a) || (ld_a && (dn_a || ab_a)))
      mon_err <= mon_err + 1;
    p_ld_a <= ld_a; p_dn_a <= dn_a; p_ab_a <= ab_a;
  end

  typedef struct {
    string       name;
    int          nclk;
    logic [11:0] hold;
    logic [0:26] oe;
    logic [0:26] ma;
    logic [0:26] mb;
    logic        done;
    logic        abort;
  } vec_t;

  localparam logic [0:26] OE_ON  = 27'b00_1111111111111111111111111;
  localparam logic [0:26] Z27    = 27'b0;
  localparam logic [0:26] A5C_T1 = 27'b000_101001011100_01110100101_0;
  localparam logic [0:26] A5C_T0 = 27'b000_101001011100_00000000000_0;
  localparam logic [0:26] FFF_T1 = 27'b000_111111111111_11111111111_0;
  localparam logic [0:26] FFF_T0 = 27'b000_111111111111_00000000000_0;
  localparam logic [0:26] V001   = 27'b000_000000000001_00000000000_0;
  localparam logic [0:26] V800T1 = 27'b000_100000000000_00000000001_0;
  localparam logic [0:26] V800T0 = 27'b000_100000000000_00000000000_0;

  vec_t vecs[10];

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic load_hold(input logic [11:0] d);
    sample_data = d; sample_valid = 1'b1;
    clk_wait(1);
    sample_valid = 1'b0;
    clk_wait(2);
  endtask

  function automatic logic [11:0] word_of(input logic [0:26] m);
    logic [11:0] w;
    for (int i = 0; i < 12; i++) w[11-i] = m[3+i];
    return w;
  endfunction

  // Master: samples at each SPICLK rise, raises CSN, then measures MISO_OE turn-off.
  task automatic run_frame(input int nclk, input bit drop, input int mid_k, input logic [11:0] mid_d,
                           output logic [0:26] oa, output logic [0:26] ma,
                           output logic [0:26] ob, output logic [0:26] mb,
                           output int lat_a, output int lat_b);
    oa = '0; ma = '0; ob = '0; mb = '0;
    if (drop) csn = 1'b0;
    clk_wait(16);
    for (int k = 0; k < nclk; k++) begin
      if (k < 27) begin
        oa[k] = if_a.miso_oe; ma[k] = if_a.miso;
        ob[k] = if_b.miso_oe; mb[k] = if_b.miso;
      end
      spiclk = 1'b1;
      if (k == mid_k) begin
        sample_data = mid_d; sample_valid = 1'b1;
        clk_wait(1);
        sample_valid = 1'b0;
        clk_wait(15);
      end else begin
        clk_wait(16);
      end
      spiclk = 1'b0;
      clk_wait(16);
    end
    csn = 1'b1;
    lat_a = 99; lat_b = 99;
    for (int c = 1; c <= 8; c++) begin
      clk_wait(1);
      if (lat_a == 99 && !if_a.miso_oe) lat_a = c;
      if (lat_b == 99 && !if_b.miso_oe) lat_b = c;
    end
    clk_wait(12);
  endtask

  initial begin
    logic [0:26] oa, ma, ob, mb;
    int la, lb, s_ld, s_dn, s_ab, s_ldb;
    n_cmp = 0; n_fail = 0;
    resetn = 1'b0; csn = 1'b1; spiclk = 1'b0; sample_valid = 1'b0; sample_data = 12'h000;

    vecs[0] = '{"a5c_27",   27, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b1, 1'b0};
    vecs[1] = '{"a5c_16",   16, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b1, 1'b0};
    vecs[2] = '{"a5c_8",     8, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b0, 1'b1};
    vecs[3] = '{"a5c_14",   14, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b1, 1'b0};
    vecs[4] = '{"a5c_13",   13, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b0, 1'b1};
    vecs[5] = '{"fff_27",   27, 12'hFFF, OE_ON, FFF_T1, FFF_T0, 1'b1, 1'b0};
    vecs[6] = '{"001_27",   27, 12'h001, OE_ON, V001,   V001,   1'b1, 1'b0};
    vecs[7] = '{"800_27",   27, 12'h800, OE_ON, V800T1, V800T0, 1'b1, 1'b0};
    vecs[8] = '{"no_clk",    0, 12'h000, Z27,   Z27,    Z27,    1'b0, 1'b1};
    vecs[9] = '{"a5c_34",   34, 12'hA5C, OE_ON, A5C_T1, A5C_T0, 1'b1, 1'b0};

    clk_wait(5);
    chk("rst_oe_a", if_a.miso_oe, 1'b0);
    chk("rst_miso_a", if_a.miso, 1'b0);
    chk("rst_loaded_a", ld_a, 1'b0);
    chk("rst_done_a", dn_a, 1'b0);
    chk("rst_abort_a", ab_a, 1'b0);
    resetn = 1'b1;
    clk_wait(10);

    for (int v = 0; v < 10; v++) begin
      load_hold(vecs[v].hold);
      s_ld = n_ld_a; s_dn = n_dn_a; s_ab = n_ab_a; s_ldb = n_ld_b;
      run_frame(vecs[v].nclk, 1'b1, -1, 12'h000, oa, ma, ob, mb, la, lb);
      for (int k = 0; k < vecs[v].nclk && k < 27; k++) begin
        chk($sformatf("%s_oe_a[%0d]", vecs[v].name, k), oa[k], vecs[v].oe[k]);
        chk($sformatf("%s_miso_a[%0d]", vecs[v].name, k), ma[k], vecs[v].ma[k]);
        chk($sformatf("%s_oe_b[%0d]", vecs[v].name, k), ob[k], vecs[v].oe[k]);
        chk($sformatf("%s_miso_b[%0d]", vecs[v].name, k), mb[k], vecs[v].mb[k]);
      end
      chk({vecs[v].name, "_loaded_a"}, n_ld_a - s_ld, 1);
      chk({vecs[v].name, "_loaded_b"}, n_ld_b - s_ldb, 1);
      chk({vecs[v].name, "_done_a"}, n_dn_a - s_dn, {31'd0, vecs[v].done});
      chk({vecs[v].name, "_abort_a"}, n_ab_a - s_ab, {31'd0, vecs[v].abort});
      chk({vecs[v].name, "_oe_off_a"}, (la <= 4), 1'b1);
      chk({vecs[v].name, "_oe_off_b"}, (lb <= 5), 1'b1);
    end

    // SAMPLE_VALID coincident with A's CSN-fall detect: A keeps the old hold, B (slower sync) gets the new one.
    load_hold(12'hFFF);
    csn = 1'b0;
    clk_wait(3);
    sample_data = 12'h123; sample_valid = 1'b1;
    clk_wait(1);
    chk("svfall_loaded_a", ld_a, 1'b1);
    sample_valid = 1'b0;
    run_frame(16, 1'b0, -1, 12'h000, oa, ma, ob, mb, la, lb);
    chk("svfall_word_a", word_of(ma), 12'hFFF);
    chk("svfall_word_b", word_of(mb), 12'h123);
    run_frame(16, 1'b1, 5, 12'h456, oa, ma, ob, mb, la, lb);
    chk("svnext_word_a", word_of(ma), 12'h123);
    chk("svmid_word_b", word_of(mb), 12'h123);

    // Reset at fall 7 with CSN held low.
    load_hold(12'h3C3);
    csn = 1'b0;
    clk_wait(16);
    for (int k = 0; k < 7; k++) begin
      spiclk = 1'b1; clk_wait(16);
      spiclk = 1'b0; clk_wait(16);
    end
    chk("pre_rst_oe_a", if_a.miso_oe, 1'b1);
    resetn = 1'b0;
    #1;
    chk("midrst_oe_a", if_a.miso_oe, 1'b0);
    chk("midrst_miso_a", if_a.miso, 1'b0);
    chk("midrst_oe_b", if_b.miso_oe, 1'b0);
    clk_wait(3);
    resetn = 1'b1;
    s_ld = n_ld_a; s_dn = n_dn_a; s_ab = n_ab_a; s_ldb = n_ld_b;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("postrst_oe_a[%0d]", k), if_a.miso_oe, 1'b0);
      chk($sformatf("postrst_oe_b[%0d]", k), if_b.miso_oe, 1'b0);
      spiclk = 1'b1; clk_wait(16);
      spiclk = 1'b0; clk_wait(16);
    end
    csn = 1'b1;
    clk_wait(16);
    chk("postrst_loaded_a", n_ld_a - s_ld, 0);
    chk("postrst_loaded_b", n_ld_b - s_ldb, 0);
    chk("postrst_pulses_a", (n_dn_a - s_dn) + (n_ab_a - s_ab), 0);
    run_frame(16, 1'b1, -1, 12'h000, oa, ma, ob, mb, la, lb);
    chk("postrst_word_a", word_of(ma), 12'h000);
    chk("postrst_null_oe_a", oa[2], 1'b1);
    chk("postrst_done_a", n_dn_a - s_dn, 1);

    // SPICLK activity with CSN high is ignored.
    s_ld = n_ld_a; s_dn = n_dn_a; s_ab = n_ab_a;
    for (int k = 0; k < 12; k++) begin
      spiclk = 1'b1; clk_wait(16);
      chk($sformatf("csnhi_oe_a[%0d]", k), if_a.miso_oe, 1'b0);
      chk($sformatf("csnhi_oe_b[%0d]", k), if_b.miso_oe, 1'b0);
      spiclk = 1'b0; clk_wait(16);
    end
    chk("csnhi_pulses_a", (n_ld_a - s_ld) + (n_dn_a - s_dn) + (n_ab_a - s_ab), 0);

    chk("pulse_shape_a", mon_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
